// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path.
//   rx_state_e         receiver FSM states
//   UART_DATA_BITS     data bits per character
//   UART_CLKS_PER_BIT  default bit period in clk cycles (40 MHz / 115200)
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 347;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for a single asynchronous input.
//   clk  in   system clock
//   rst  in   synchronous active-high reset; both flops load RST_VAL
//   d_i  in   asynchronous input
//   q_o  out  synchronized output (2 cycles latency)
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Deframes 8-bit characters from usb_rs232_rxd and
// hands them over with a valid/ack level handshake.
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   usb_rs232_rxd  in   asynchronous serial line, idle high
//   rx_ack         in   consumer accepts rx_data
//   rx_data        out  last received character
//   rx_valid       out  rx_data unconsumed
//   rx_busy        out  frame in progress
//   rx_frame_err   out  pulse: stop bit sampled low
//   rx_overrun     out  pulse: character dropped, previous not consumed
//   rx_parity_err  out  pulse: even-parity mismatch (0 unless parity built)
// Build option: define UART_RX_PARITY_EN for an 8E1 frame; default is 8N1.
//
// state  | meaning
// IDLE   | line idle, waiting for rxd_s low
// START  | half a bit period in, confirm start bit
// DATA   | sample 8 data bits LSB first at end of each period
// PARITY | sample even-parity bit (parity build only)
// STOP   | sample stop bit, complete or flag framing error
// BREAK  | line held low after framing error, wait for high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_rs232_rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic rxd_s;

  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      fe_q, fe_d;
  logic                      ov_q, ov_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_q, par_d;
  logic                      pe_q, pe_d;
`endif

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (usb_rs232_rxd),
    .q_o (rxd_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rxd_s) state_d = START;
      START: if (cnt_q == CNT_HALF) state_d = rxd_s ? IDLE : DATA;
      DATA: begin
        if (cnt_q == CNT_LAST && idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == CNT_LAST) state_d = STOP;
`endif
      // Back to IDLE right after the stop sample so a following start
      // bit with no extra idle time is still caught.
      STOP:  if (cnt_q == CNT_LAST) state_d = rxd_s ? IDLE : BREAK;
      BREAK: if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    // An ack clears the level; a completion below may set it again.
    valid_d = valid_q & ~rx_ack;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif
    case (state_q)
      IDLE, BREAK: cnt_d = '0;
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s;
          idx_d          = idx_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          par_d = rxd_s;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            if (!valid_q || rx_ack) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            pe_d = par_q ^ (^shift_q);
`endif
          end else begin
            // Bad stop bit: character is discarded entirely.
            fe_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = (state_q != IDLE);
  assign rx_frame_err = fe_q;
  assign rx_overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = pe_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed stimulus for uart_rx with a
// transaction-level reference model (frame queue + completion-time formula).
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Bit periods from start check to stop sample, and pin-fall-to-output latency.
  localparam int SAMPLES = 9 + PAR;
  localparam int LAT     = 3 + HALF + SAMPLES * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .usb_rs232_rxd (rxd),
    .rx_ack        (ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_busy       (rx_busy),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_parity_err (rx_parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] data;
    bit         stop_ok;
    bit         par_ok;
  } exp_t;
  exp_t q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int n_sent = 0;
  int last_k = 0;

  // Model state
  logic       mvalid = 1'b0;
  logic [7:0] mdata  = 8'h00;
  logic       e_fe, e_ov, e_pe;
  logic       rst_prev = 1'b0, ack_prev = 1'b0;
  bit         armed = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    e_fe = 1'b0; e_ov = 1'b0; e_pe = 1'b0;
    if (rst_prev) begin
      mvalid = 1'b0;
      mdata  = 8'h00;
      q.delete();
      armed  = 1'b1;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (!e.stop_ok) begin
        e_fe = 1'b1;
        if (ack_prev) mvalid = 1'b0;
      end else begin
        e_pe = !e.par_ok;
        if (!mvalid || ack_prev) begin
          mvalid = 1'b1;
          mdata  = e.data;
        end else begin
          e_ov = 1'b1;
        end
      end
    end else if (ack_prev) begin
      mvalid = 1'b0;
    end
    if (armed) begin
      n_cmp++;
      if ({rx_valid, rx_data, rx_frame_err, rx_overrun, rx_parity_err} !==
          {mvalid, mdata, e_fe, e_ov, e_pe}) begin
        n_fail++;
        $display("FAIL cycle %0d outputs: got valid=%0b data=%02h fe=%0b ov=%0b pe=%0b, expected valid=%0b data=%02h fe=%0b ov=%0b pe=%0b",
                 cyc, rx_valid, rx_data, rx_frame_err, rx_overrun, rx_parity_err,
                 mvalid, mdata, e_fe, e_ov, e_pe);
      end
      if (rx_frame_err)  fe_cnt++;
      if (rx_overrun)    ov_cnt++;
      if (rx_parity_err) pe_cnt++;
    end
    rst_prev = rst;
    ack_prev = ack;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All bench actions happen 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_bit);
    exp_t e;
    e.due     = cyc + LAT;
    e.data    = d;
    e.stop_ok = stop_bit;
    e.par_ok  = (PAR == 0) || (par_bit == ^d);
    q.push_back(e);
    last_k = cyc;
    n_sent++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR != 0) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int base, fe0, ov0, pe0;
    bit done;
    tick(3);
    rst = 1'b0;
    tick(5);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_busy",  {31'd0, rx_busy},  32'd0);

    // Nominal
    send_frame(8'hA5, 1'b1, ^8'hA5);
    tick(5);
    chk("nominal_data",  {24'd0, rx_data}, 32'hA5);
    chk("nominal_valid", {31'd0, rx_valid}, 32'd1);
    ack_pulse();
    tick(1);
    chk("nominal_valid_cleared", {31'd0, rx_valid}, 32'd0);

    // Glitch shorter than half a bit
    rxd = 1'b0;
    tick(6);
    chk("glitch_busy_during", {31'd0, rx_busy}, 32'd1);
    rxd = 1'b1;
    tick(20);
    chk("glitch_busy_after", {31'd0, rx_busy}, 32'd0);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);

    // Framing error with line held low
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    tick(40);
    chk("frame_err_count", fe_cnt - fe0, 32'd1);
    chk("frame_err_valid", {31'd0, rx_valid}, 32'd0);
    chk("frame_err_break_busy", {31'd0, rx_busy}, 32'd1);
    rxd = 1'b1;
    tick(5);
    chk("frame_err_idle", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h11, 1'b1, ^8'h11);
    tick(2);
    chk("after_break_data", {24'd0, rx_data}, 32'h11);
    ack_pulse();
    tick(2);

    // Overrun: back-to-back, no ack
    ov0 = ov_cnt;
    send_frame(8'h01, 1'b1, ^8'h01);
    send_frame(8'h02, 1'b1, ^8'h02);
    tick(2);
    chk("overrun_data",  {24'd0, rx_data}, 32'h01);
    chk("overrun_count", ov_cnt - ov0, 32'd1);
    ack_pulse();
    tick(2);

    // Ack landing in the completion cycle of the second frame
    ov0  = ov_cnt;
    base = n_sent;
    fork
      begin
        send_frame(8'h01, 1'b1, ^8'h01);
        send_frame(8'h02, 1'b1, ^8'h02);
      end
      begin
        int target;
        wait (n_sent == base + 2);
        target = last_k + LAT;
        while (cyc < target - 1) tick(1);
        ack_pulse();
      end
    join
    tick(2);
    chk("ack_same_cycle_data",  {24'd0, rx_data}, 32'h02);
    chk("ack_same_cycle_valid", {31'd0, rx_valid}, 32'd1);
    chk("ack_same_cycle_no_ov", ov_cnt - ov0, 32'd0);
    tick(3);

    // Reset during data bit 4 of 0xFF (valid left high beforehand)
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    tick(HALF);
    rst = 1'b1;
    tick(1);
    chk("rst_data",  {24'd0, rx_data}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy",  {31'd0, rx_busy}, 32'd0);
    chk("rst_pulses", {29'd0, rx_frame_err, rx_overrun, rx_parity_err}, 32'd0);
    rst = 1'b0;
    rxd = 1'b1;
    tick(2 * CPB);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    tick(2);
    chk("post_reset_data", {24'd0, rx_data}, 32'h5A);
    ack_pulse();
    tick(2);

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    tick(2);
    chk("parity_bad_count", pe_cnt - pe0, 32'd1);
    chk("parity_bad_data",  {24'd0, rx_data}, 32'h07);
    chk("parity_bad_valid", {31'd0, rx_valid}, 32'd1);
    ack_pulse();
    tick(2);
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    tick(2);
    chk("parity_good_count", pe_cnt - pe0, 32'd0);
    ack_pulse();
    tick(2);
`else
    pe0 = pe_cnt;
`endif

    // Randomized frames, gaps and acks
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          logic [7:0] d;
          bit s, p;
          d = 8'($urandom);
          s = ($urandom % 8) != 0;
          p = (^d) ^ (($urandom % 4) == 0);
          send_frame(d, s, p);
          rxd = 1'b1;
          if (!s) tick(3 + $urandom % 10);
          else    tick($urandom % 4);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ack = (($urandom % 6) == 0);
          tick(1);
        end
        ack = 1'b0;
      end
    join
    tick(LAT + 20);
    chk("queue_drained", q.size(), 32'd0);
`ifndef UART_RX_PARITY_EN
    chk("parity_tied_low", pe_cnt - pe0, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: samples the asynchronous `usb_rs232_rxd` line, deframes 8-bit characters and presents them to the fabric through a valid/ack handshake. It is the receive-side counterpart of the UART transmit path and shares the same system clock and bit timing. It reports framing, overrun and, optionally, parity errors.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 347: clock cycles per bit. 40 MHz / 115200 ≈ 347. Minimum legal value is 4.

**Ports**
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `usb_rs232_rxd`  in  1  asynchronous serial line; idle high.
- `rx_ack`  in  1  consumer accepts `rx_data`; clears `rx_valid`.
- `rx_data`  out  8  last received character.
- `rx_valid`  out  1  level; high while `rx_data` is unconsumed.
- `rx_busy`  out  1  high while a frame is in progress (any state except IDLE).
- `rx_frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `rx_overrun`  out  1  one-cycle pulse; a character completed while `rx_valid` was high and `rx_ack` was low.
- `rx_parity_err`  out  1  one-cycle pulse; parity mismatch. Tied 0 when parity is compiled out.

## Operation

- **Synchronizer:** 2-flop synchronizer on `usb_rs232_rxd`, reset to 1. All logic uses the synchronized `rxd_s`.
- **Bit counter:** `bit_cnt` is `$clog2(CLKS_PER_BIT)` bits wide. `HALF` = `CLKS_PER_BIT/2`, floor.
- **IDLE:** counter held at 0. When `rxd_s`==0, go to START.
- **START:** count to `HALF-1`, then sample.
  - `rxd_s`==1: false start; return to IDLE with no flags.
  - `rxd_s`==0: zero the counter and go to DATA with index 0.
- **DATA:** at `bit_cnt`==`CLKS_PER_BIT-1`, sample `rxd_s` into shift register bit `index` (LSB first) and zero the counter. After index 7, go to PARITY if compiled in, else STOP.
- **PARITY:** one bit period. The sample is compared with even parity over the 8 data bits.
- **STOP:** sample at `CLKS_PER_BIT-1`.
  - Sample 1: character complete; go to IDLE.
  - Sample 0: pulse `rx_frame_err`, discard the character (no `rx_valid`, no overrun, no parity_err), go to BREAK.
- **BREAK:** wait for `rxd_s`==1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- **Completion:**
  - If `rx_valid`==0, or `rx_ack`==1 in the same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise: keep the old data, drop the new character, pulse `rx_overrun`.
- **Parity result:**
  - Mismatch pulses `rx_parity_err` in the completion cycle.
  - The character is still delivered and is still subject to the overrun rules.
- **Ack:** `rx_ack` while `rx_valid`==0 has no effect.
- **Reset:** `rst` in any state forces IDLE at the next edge and aborts a partial frame silently.
  - Reset values: `rx_data`=0, `rx_valid`=0, `rx_busy`=0, all error pulses 0, synchronizer flops 1.

## Timing

- The synchronizer adds 2 cycles of latency from the pin.
- Start is detected on the first cycle `rxd_s` is 0.
- The start check occurs `HALF` cycles after entering START. Data bit n is sampled `(n+1)*CLKS_PER_BIT` cycles after the start check.
- `rx_valid` rises, or the error pulse fires, on the edge following the stop-bit sample.
- Cycles from the pin falling edge to `rx_valid`: 2 + 1 + `HALF` + 9·`CLKS_PER_BIT` (+`CLKS_PER_BIT` with parity), ±1.
- `rx_valid` falls on the edge after `rx_ack` is sampled high.
- IDLE is re-entered right after the stop sample, so back-to-back frames with a single stop bit are received.

## Configuration

- Macro: `UART_RX_PARITY_EN`.
- **Defined:** frame is start, 8 data, 1 even-parity bit, 1 stop. PARITY state exists and `rx_parity_err` is live.
- **Undefined:** 8N1 frame. PARITY state is absent and `rx_parity_err` is constant 0.
- The port list is identical in both builds.

## Structure

- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `UART_DATA_BITS`=8;
  - the default `CLKS_PER_BIT`=347.
- One sub-module, `uart_sync`: a 2-flop synchronizer with a reset-value parameter.

## Test plan

All scenarios use `CLKS_PER_BIT`=16.

- **Nominal:** send 0xA5, 8N1, ack 5 cycles later. `rx_data`=0xA5, `rx_valid` high for exactly the cycles until ack +1, no error flags.
- **Glitch:** drive the line low for 6 cycles. No `rx_valid`, `rx_busy` returns to 0 after the START check, no flags.
- **Framing error:** send 0x3C with stop bit 0, holding the line low 40 more cycles. One `rx_frame_err` pulse, no `rx_valid`, no further frames until the line rises. Then 0x11 is received correctly.
- **Overrun:** send 0x01 then 0x02 back-to-back with no ack. `rx_data`=0x01, one `rx_overrun` pulse. Repeat with ack asserted in the 0x02 completion cycle: `rx_data`=0x02 and no overrun.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xFF. All outputs at reset values; the next frame 0x5A is received correctly.
- **Parity (`UART_RX_PARITY_EN`):** send 0x07 with parity bit 0. `rx_parity_err` pulses and `rx_data`=0x07 with `rx_valid`=1. With parity bit 1: no error.
